// File: rtl/serial_adder.sv
// Bit-serial, LSB-first adder. Two half adders plus an OR form the full adder,
// and a carry flip-flop closes the loop. Start/busy/done handshake toward the sequencer.
module serial_adder #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_sum,
    output logic         o_carry
);
    localparam int            CW   = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  r_sa;
    logic [W-1:0]  r_sb;
    logic [W-1:0]  r_acc;
    logic [W-1:0]  acc_next;
    logic [CW-1:0] cnt;
    logic          carry_ff;
    logic          s1, c1, s2, c2;
    logic          carry_next;
    logic          last_bit;

    // Full adder built from the two half-adder sum/carry pairs.
    assign s1         = r_sa[0] ^ r_sb[0];
    assign c1         = r_sa[0] & r_sb[0];
    assign s2         = s1 ^ carry_ff;
    assign c2         = s1 & carry_ff;
    assign carry_next = c1 | c2;
    assign last_bit   = (cnt == LAST);

    // Result bit enters at the MSB, so after W shifts bit 0 has reached position 0.
    assign acc_next   = (r_acc >> 1) | (W'(s2) << (W - 1));

    assign o_busy = (state == RUN);
    assign o_done = (state == DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case leaves
        // state_next unassigned and infers a latch.
        state_next = state;
        case (state)
            IDLE:    if (i_start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_acc    <= '0;
            cnt      <= '0;
            carry_ff <= 1'b0;
            o_sum    <= '0;
            o_carry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        r_sa     <= i_a;
                        r_sb     <= i_b;
                        r_acc    <= '0;
                        cnt      <= '0;
                        carry_ff <= 1'b0;
                    end
                end
                RUN: begin
                    r_sa     <= r_sa >> 1;
                    r_sb     <= r_sb >> 1;
                    r_acc    <= acc_next;
                    carry_ff <= carry_next;
                    cnt      <= cnt + CW'(1);
                    if (last_bit) begin
                        o_sum   <= acc_next;
                        o_carry <= carry_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a W=4 instance for the main checks and a W=1
// instance for the single-bit corner, sharing clock and reset.
module tb_serial_adder;
    localparam int W4 = 4;

    logic          clk;
    logic          rst_n;
    logic          start4, busy4, done4, carry4;
    logic [W4-1:0] a4, b4, sum4;
    logic          start1, busy1, done1, carry1;
    logic [0:0]    a1, b1, sum1;

    int total = 0;
    int bad   = 0;

    serial_adder #(.W(W4)) dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start4),
        .i_a     (a4),
        .i_b     (b4),
        .o_busy  (busy4),
        .o_done  (done4),
        .o_sum   (sum4),
        .o_carry (carry4)
    );

    serial_adder #(.W(1)) dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start1),
        .i_a     (a1),
        .i_b     (b1),
        .o_busy  (busy1),
        .o_done  (done1),
        .o_sum   (sum1),
        .o_carry (carry1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One add on the W=4 instance: busy for W cycles, one done pulse, outputs held.
    task automatic run4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] es, input logic ec, input string tag);
        int         busy_n;
        logic [4:0] prev;
        prev   = {sum4, carry4};
        busy_n = 0;
        @(negedge clk);
        start4 = 1'b1;
        a4     = a;
        b4     = b;
        @(posedge clk); #1;
        start4 = 1'b0;
        a4     = ~a;
        b4     = ~b;
        for (int i = 0; i < W4 + 3 && !done4; i++) begin
            if (busy4) busy_n++;
            check({tag, "_hold"}, {sum4, carry4}, prev);
            @(posedge clk); #1;
        end
        check({tag, "_busy_cycles"}, busy_n, W4);
        check({tag, "_done"}, done4, 1'b1);
        check({tag, "_busy_in_done"}, busy4, 1'b0);
        check({tag, "_sum"}, sum4, es);
        check({tag, "_carry"}, carry4, ec);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done4, 1'b0);
        check({tag, "_idle_hold"}, {sum4, carry4}, {es, ec});
    endtask

    initial begin
        rst_n  = 1'b0;
        start4 = 1'b0;
        a4     = '0;
        b4     = '0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        #2;
        check("rst_busy4", busy4, 1'b0);
        check("rst_done4", done4, 1'b0);
        check("rst_sum4", sum4, 4'd0);
        check("rst_carry4", carry4, 1'b0);
        check("rst_busy1", busy1, 1'b0);
        check("rst_sum1", sum1, 1'b0);
        check("rst_carry1", carry1, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run4(4'd3, 4'd5, 4'd8, 1'b0, "add_3_5");
        repeat (3) begin
            @(posedge clk); #1;
            check("idle_hold_8", {sum4, carry4}, {4'd8, 1'b0});
        end
        run4(4'd15, 4'd1, 4'd0, 1'b1, "add_15_1");
        run4(4'd15, 4'd15, 4'd14, 1'b1, "add_15_15");
        run4(4'd0, 4'd0, 4'd0, 1'b0, "add_0_0");

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [4:0] ref_sum;
                ref_sum = 5'(a) + 5'(b);
                run4(4'(a), 4'(b), ref_sum[3:0], ref_sum[4], $sformatf("sweep_%0d_%0d", a, b));
            end
        end

        // Start held high with operands changing every cycle: 6+7, then 5+10.
        @(negedge clk);
        start4 = 1'b1;
        a4     = 4'd6;
        b4     = 4'd7;
        @(posedge clk); #1;
        for (int j = 0; j <= 2 * W4 + 3; j++) begin
            check($sformatf("cont_busy_%0d", j), busy4,
                  (j < W4) || (j >= W4 + 2 && j < 2 * W4 + 2));
            check($sformatf("cont_done_%0d", j), done4, (j == W4) || (j == 2 * W4 + 2));
            if (j == W4) begin
                check("cont_sum_13", sum4, 4'd13);
                check("cont_carry_13", carry4, 1'b0);
            end
            if (j == 2 * W4 + 2) begin
                check("cont_sum_15", sum4, 4'd15);
                check("cont_carry_15", carry4, 1'b0);
            end
            a4 = 4'(j);
            b4 = 4'(15 - j);
            if (j == 2 * W4 + 3) begin
                start4 = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end

        // Reset two cycles into a 9+9 add, asserted between clock edges.
        @(negedge clk);
        start4 = 1'b1;
        a4     = 4'd9;
        b4     = 4'd9;
        @(posedge clk); #1;
        start4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrun_busy", busy4, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", busy4, 1'b0);
        check("midrun_rst_done", done4, 1'b0);
        check("midrun_rst_sum", sum4, 4'd0);
        check("midrun_rst_carry", carry4, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < W4 + 3; j++) begin
            @(posedge clk); #1;
            check($sformatf("post_rst_no_done_%0d", j), done4, 1'b0);
            check($sformatf("post_rst_no_busy_%0d", j), busy4, 1'b0);
        end
        run4(4'd2, 4'd2, 4'd4, 1'b0, "after_rst_2_2");

        // Asynchronous reset while idle with a held result.
        #2 rst_n = 1'b0;
        #1;
        check("idle_rst_sum", sum4, 4'd0);
        check("idle_rst_carry", carry4, 1'b0);
        #2 rst_n = 1'b1;
        run4(4'd1, 4'd2, 4'd3, 1'b0, "after_idle_rst_1_2");

        // W=1 instance: 1+1 then 1+0.
        for (int t = 0; t < 2; t++) begin
            logic [0:0] eb;
            logic [0:0] es;
            logic       ec;
            eb = (t == 0) ? 1'b1 : 1'b0;
            es = (t == 0) ? 1'b0 : 1'b1;
            ec = (t == 0) ? 1'b1 : 1'b0;
            @(negedge clk);
            start1 = 1'b1;
            a1     = 1'b1;
            b1     = eb;
            @(posedge clk); #1;
            start1 = 1'b0;
            a1     = 1'b0;
            b1     = 1'b0;
            check($sformatf("w1_%0d_busy", t), busy1, 1'b1);
            check($sformatf("w1_%0d_no_done", t), done1, 1'b0);
            @(posedge clk); #1;
            check($sformatf("w1_%0d_done", t), done1, 1'b1);
            check($sformatf("w1_%0d_busy_off", t), busy1, 1'b0);
            check($sformatf("w1_%0d_sum", t), sum1, es);
            check($sformatf("w1_%0d_carry", t), carry1, ec);
            @(posedge clk); #1;
            check($sformatf("w1_%0d_done_pulse", t), done1, 1'b0);
            check($sformatf("w1_%0d_hold", t), {sum1, carry1}, {es, ec});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial, LSB-first adder that consumes the half-adder sum/carry pair. Two half adders plus an OR form a full adder, and a carry flip-flop closes the loop.
- Adds two W-bit operands over W clock cycles and presents a registered sum and carry-out.
- Sits in the CPU datapath as the small-area ALU add path, downstream of the half-adder cell.
- Uses a start/busy/done handshake toward the sequencer.

Parameters:
- W, 4, operand and sum width in bits. Legal range W >= 1.

Ports:
- i_clk  input  1  system clock; all state changes on the rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_start  input  1  request an add; sampled only in IDLE.
- i_a  input  W  operand A; captured on the accepted i_start edge.
- i_b  input  W  operand B; captured on the accepted i_start edge.
- o_busy  output  1  high while state is RUN.
- o_done  output  1  one-cycle pulse; result valid.
- o_sum  output  W  registered sum (A+B) mod 2^W.
- o_carry  output  1  registered carry-out of bit W-1.

Behaviour:
- Reset (i_rst_n low, asynchronous, any state):
  - State goes to IDLE.
  - o_busy=0, o_done=0, o_sum=0, o_carry=0.
  - Internal shift registers, carry flip-flop and bit counter all clear to 0.
  - An operation in flight is discarded; no o_done is produced for it.
- States: IDLE, RUN, DONE. The encoding is implementer's choice.
- IDLE:
  - i_start=1 at an edge → capture i_a into r_sa and i_b into r_sb.
  - Same edge: clear the carry flip-flop and counter=0, then go to RUN.
  - o_sum and o_carry hold their previous result.
- RUN (one bit per edge):
  - Half adder 1 computes (r_sa[0], r_sb[0]) → c1, s1.
  - Half adder 2 computes (s1, carry_ff) → c2, s2.
  - Result bit = s2; next carry = c1 | c2.
  - r_sa and r_sb shift right by one. The result bit shifts into the MSB of the internal accumulator r_acc.
  - Counter increments.
  - At the edge where counter==W-1, the final bit is processed. On that same edge:
    - o_sum <= the completed accumulator value, including this bit.
    - o_carry <= the next carry.
    - State goes to DONE.
- DONE: lasts exactly one cycle with o_done=1, then returns to IDLE unconditionally.
- Latency: accepted i_start at edge k → o_busy high for cycles k+1..k+W. o_done is high in the cycle after edge k+W.
- Minimum issue interval is W+2 edges. This gives a fresh o_done pulse per operation.
- o_busy = (state==RUN) and o_done = (state==DONE). Both are decoded from registered state, with no combinational path from inputs.
- i_start is ignored in RUN and DONE: no re-capture and no queuing. It must be re-asserted in IDLE.
- Operand changes on i_a/i_b after capture have no effect on the running add.
- o_sum/o_carry change only on entry to DONE (or on reset). They are stable while busy, and are held indefinitely in IDLE.
- W=1: a single RUN cycle, then DONE. Counter width is max(1, clog2(W)).
- Arithmetic is unsigned. Signed overflow detection is not provided (out of scope).

Test Plan:
- W=4: i_a=3, i_b=5, start pulse → o_busy high 4 cycles, then o_done pulse. o_sum=8, o_carry=0, held in IDLE.
- W=4: 15+1 → o_sum=0, o_carry=1. 15+15 → o_sum=14, o_carry=1. 0+0 → o_sum=0, o_carry=0. Exhaustive 256-pair sweep must match (a+b) with no mismatch.
- Hold i_start high continuously with changing operands:
  - Exactly one capture per IDLE visit; a new op starts every W+2 edges.
  - Mid-run operand changes do not alter the result.
  - 6+7 → 13, carry 0.
- Assert i_rst_n low 2 cycles into a 9+9 add:
  - All outputs 0 immediately, without waiting for a clock.
  - No o_done appears.
  - Next 2+2 after release gives o_sum=4.
- Reset applied asynchronously between clock edges → outputs clear before the next rising edge. First start after deassertion is accepted normally.
- W=1 build: 1+1 → o_busy 1 cycle, o_sum=0, o_carry=1. 1+0 → o_sum=1, o_carry=0.
